otter_alu_pipe: RTL and testbench

OTTER_ALU_PIPE -- requirements
Module: otter_alu_pipe

---
 rtl/otter_alu_pipe.sv | 104 ++++++++++
 tb/tb_otter_alu_pipe.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/otter_alu_pipe.sv
// otter_alu_pipe: ALU plus pipelined multiplier sharing one CDB result slot; define OTTER_ALU_MULH_EN for mulh/mulhsu/mulhu
module otter_alu_pipe #(
  parameter int XLEN = 32,
  parameter int TAG_W = 5,
  parameter int MUL_LAT = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       issue_fun,
  input  logic [XLEN-1:0]  issue_v1,
  input  logic [XLEN-1:0]  issue_v2,
  input  logic [TAG_W-1:0] issue_tag,
  output logic             cdb_valid,
  input  logic             cdb_grant,
  output logic [XLEN-1:0]  cdb_val,
  output logic [TAG_W-1:0] cdb_tag,
  output logic             busy
);
  localparam int SW = $clog2(XLEN);
  // The result slot is the final multiply register, so only MUL_LAT-1 stages sit in front of it.
  localparam logic PIPED = MUL_LAT > 1;
  localparam int D = PIPED ? MUL_LAT - 1 : 1;

  logic [D-1:0]     sv;
  logic [TAG_W-1:0] st [D];
  logic [XLEN-1:0]  sd [D];
  logic             is_mul, out_free, last_valid, advance, accept;
  logic [XLEN-1:0]  alu_res, mul_res;
  logic [SW-1:0]    sh;

`ifdef OTTER_ALU_MULH_EN
  logic [2*XLEN-1:0] a_ext, b_ext, prod;
  assign is_mul = issue_fun inside {4'd10, 4'd11, 4'd12, 4'd14};
  assign a_ext = issue_fun == 4'd14 ? {{XLEN{1'b0}}, issue_v1} : {{XLEN{issue_v1[XLEN-1]}}, issue_v1};
  assign b_ext = issue_fun == 4'd11 ? {{XLEN{issue_v2[XLEN-1]}}, issue_v2} : {{XLEN{1'b0}}, issue_v2};
  assign prod = a_ext * b_ext;
  assign mul_res = issue_fun == 4'd10 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
`else
  assign is_mul = issue_fun == 4'd10;
  assign mul_res = issue_v1 * issue_v2;
`endif

  assign sh = issue_v2[SW-1:0];
  assign out_free = !cdb_valid || cdb_grant;
  assign last_valid = PIPED && sv[D-1];
  assign advance = !last_valid || out_free;
  assign issue_ready = !flush && !RST && (is_mul ? advance : out_free && !last_valid);
  assign accept = issue_valid && issue_ready;
  assign busy = |sv || cdb_valid;

  always_comb begin
    alu_res = '0;
    case (issue_fun)
      4'd0:    alu_res = issue_v1 + issue_v2;
      4'd8:    alu_res = issue_v1 - issue_v2;
      4'd6:    alu_res = issue_v1 | issue_v2;
      4'd7:    alu_res = issue_v1 & issue_v2;
      4'd4:    alu_res = issue_v1 ^ issue_v2;
      4'd1:    alu_res = issue_v1 << sh;
      4'd5:    alu_res = issue_v1 >> sh;
      4'd13:   alu_res = XLEN'($signed(issue_v1) >>> sh);
      4'd2:    alu_res = XLEN'($signed(issue_v1) < $signed(issue_v2));
      4'd3:    alu_res = XLEN'(issue_v1 < issue_v2);
      4'd9:    alu_res = issue_v1;
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST || flush) sv <= '0;
    else if (advance) begin
      for (int i = D - 1; i > 0; i--) begin
        sv[i] <= sv[i-1];
        st[i] <= st[i-1];
        sd[i] <= sd[i-1];
      end
      sv[0] <= PIPED && accept && is_mul;
      st[0] <= issue_tag;
      sd[0] <= mul_res;
    end
  end

  // A draining multiply wins the slot; ALU issue is already held off by issue_ready in that case.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cdb_valid <= 1'b0;
      cdb_val <= '0;
      cdb_tag <= '0;
    end else if (flush) cdb_valid <= 1'b0;
    else if (out_free) begin
      cdb_valid <= last_valid || (accept && (!is_mul || !PIPED));
      if (last_valid) begin
        cdb_val <= sd[D-1];
        cdb_tag <= st[D-1];
      end else if (accept) begin
        cdb_val <= is_mul ? mul_res : alu_res;
        cdb_tag <= issue_tag;
      end
    end
  end
endmodule

// File: tb/tb_otter_alu_pipe.sv
// tb_otter_alu_pipe: directed and randomized checks of otter_alu_pipe against a timing-level scoreboard model
module tb_otter_alu_pipe;
  localparam int MUL_LAT = 3;

  logic        clk, rst, flush, issue_valid, issue_ready, cdb_valid, cdb_grant, busy;
  logic [3:0]  issue_fun;
  logic [31:0] issue_v1, issue_v2, cdb_val;
  logic [4:0]  issue_tag, cdb_tag;

  otter_alu_pipe #(.XLEN(32), .TAG_W(5), .MUL_LAT(MUL_LAT)) dut (
    .CLK(clk), .RST(rst), .flush(flush), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_fun(issue_fun), .issue_v1(issue_v1), .issue_v2(issue_v2), .issue_tag(issue_tag),
    .cdb_valid(cdb_valid), .cdb_grant(cdb_grant), .cdb_val(cdb_val), .cdb_tag(cdb_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] val;
    logic [4:0]  tag;
    int          acc;
  } mres_t;

  mres_t       mul_q [$];
  int          tests = 0, fails = 0, cyc = 0;
  logic        grant_hi = 1'b0, prev_free = 1'b1, alu_just = 1'b0, rst_prev = 1'b0, flush_prev = 1'b0;
  logic [31:0] alu_val, slot_val;
  logic [4:0]  alu_tag, slot_tag;

  function automatic logic bench_is_mul(logic [3:0] f);
`ifdef OTTER_ALU_MULH_EN
    return f == 4'd10 || f == 4'd11 || f == 4'd12 || f == 4'd14;
`else
    return f == 4'd10;
`endif
  endfunction

  function automatic logic [31:0] ref_res(logic [3:0] f, logic [31:0] a, logic [31:0] b);
    longint          sa = longint'($signed(a));
    longint          sb = longint'($signed(b));
    longint unsigned ua = 64'(a);
    longint unsigned ub = 64'(b);
    int              s = int'(b & 32'd31);
    case (f)
      4'd0:  return a + b;
      4'd8:  return a - b;
      4'd6:  return a | b;
      4'd7:  return a & b;
      4'd4:  return a ^ b;
      4'd1:  return a << s;
      4'd5:  return a >> s;
      4'd13: return 32'(sa >>> s);
      4'd2:  return sa < sb ? 32'd1 : 32'd0;
      4'd3:  return ua < ub ? 32'd1 : 32'd0;
      4'd9:  return a;
      4'd10: return 32'(ua * ub);
`ifdef OTTER_ALU_MULH_EN
      4'd11: return 32'((sa * sb) >>> 32);
      4'd12: return 32'((sa * longint'(ub)) >>> 32);
      4'd14: return 32'((ua * ub) >> 32);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic chk(string name, logic [63:0] obs, logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", name, obs, exp, cyc);
    end
  endtask

  task automatic set_issue(logic v, logic [3:0] f, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    issue_valid = v;
    issue_fun = f;
    issue_v1 = a;
    issue_v2 = b;
    issue_tag = t;
  endtask

  // One clock: observe at negedge, update the scoreboard, advance past the next rising edge.
  task automatic step();
    mres_t e;
    logic  fresh, exp_rdy;
    @(negedge clk);
    if (rst_prev) begin
      chk("rst_valid", cdb_valid, 0);
      chk("rst_val", cdb_val, 0);
      chk("rst_tag", cdb_tag, 0);
      chk("rst_busy", busy, 0);
    end
    if (flush_prev) begin
      chk("flush_valid", cdb_valid, 0);
      chk("flush_busy", busy, 0);
    end
    if (!rst) begin
      fresh = cdb_valid && prev_free;
      if (alu_just) begin
        chk("alu_valid", cdb_valid, 1);
        chk("alu_result", {cdb_tag, cdb_val}, {alu_tag, alu_val});
        slot_tag = alu_tag;
        slot_val = alu_val;
      end else if (fresh) begin
        if (mul_q.size() == 0) chk("spurious_valid", cdb_valid, 0);
        else begin
          e = mul_q.pop_front();
          chk("mul_result", {cdb_tag, cdb_val}, {e.tag, e.val});
          if (grant_hi) chk("mul_latency", cyc - e.acc, MUL_LAT);
          slot_tag = e.tag;
          slot_val = e.val;
        end
      end else if (!prev_free) begin
        chk("hold_valid", cdb_valid, 1);
        chk("hold_result", {cdb_tag, cdb_val}, {slot_tag, slot_val});
      end
      if (grant_hi && !flush && cdb_grant) begin
        exp_rdy = 1'b1;
        if (!bench_is_mul(issue_fun))
          foreach (mul_q[i]) if (mul_q[i].acc == cyc - (MUL_LAT - 1)) exp_rdy = 1'b0;
        chk("issue_ready", issue_ready, exp_rdy);
      end
    end
    if (rst || flush) chk(rst ? "rst_ready" : "flush_ready", issue_ready, 0);
    alu_just = 1'b0;
    rst_prev = rst;
    flush_prev = flush && !rst;
    if (rst || flush) begin
      mul_q.delete();
      prev_free = 1'b1;
    end else begin
      prev_free = !cdb_valid || cdb_grant;
      if (issue_valid && issue_ready) begin
        if (bench_is_mul(issue_fun)) mul_q.push_back('{ref_res(issue_fun, issue_v1, issue_v2), issue_tag, cyc});
        else begin
          alu_just = 1'b1;
          alu_val = ref_res(issue_fun, issue_v1, issue_v2);
          alu_tag = issue_tag;
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    issue_valid = 1'b0;
    flush = 1'b0;
    cdb_grant = 1'b1;
    for (int i = 0; i < 40 && (busy || alu_just || mul_q.size() != 0); i++) step();
    chk("drain_busy", busy, 0);
    chk("drain_lost", mul_q.size(), 0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    cdb_grant = 1'b1;
    set_issue(0, 0, 0, 0, 0);
    step();
    step();
    rst = 1'b0;
    step();
    grant_hi = 1'b1;

    set_issue(1, 4'd0, 32'd5, 32'd7, 5'd3);
    step();
    chk("add_5_7", {cdb_valid, cdb_tag, cdb_val}, {1'b1, 5'd3, 32'd12});
    drain();

    set_issue(1, 4'd10, 32'hFFFF_FFFF, 32'd2, 5'd1);
    step();
    issue_valid = 1'b0;
    step();
    chk("mul_not_early", cdb_valid, 0);
    step();
    chk("mul_ff_x2", {cdb_valid, cdb_tag, cdb_val}, {1'b1, 5'd1, 32'hFFFF_FFFE});
    drain();

    set_issue(1, 4'd10, 32'd3, 32'd4, 5'd1);
    step();
    set_issue(1, 4'd0, 32'd1, 32'd1, 5'd2);
    step();
    issue_valid = 1'b0;
    chk("alu_first", {cdb_valid, cdb_tag, cdb_val}, {1'b1, 5'd2, 32'd2});
    step();
    chk("mul_second", {cdb_valid, cdb_tag, cdb_val}, {1'b1, 5'd1, 32'd12});
    drain();

    grant_hi = 1'b0;
    set_issue(1, 4'd0, 32'd10, 32'd20, 5'd7);
    step();
    cdb_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_issue(1, 4'd10, $urandom, $urandom, 5'(8 + i));
      step();
    end
    #1;
    chk("stall_ready", issue_ready, 0);
    step();
    drain();

    set_issue(1, 4'd0, 32'd1, 32'd2, 5'd19);
    step();
    cdb_grant = 1'b0;
    set_issue(1, 4'd10, 32'd5, 32'd6, 5'd20);
    step();
    set_issue(1, 4'd10, 32'd7, 32'd8, 5'd21);
    step();
    flush = 1'b1;
    cdb_grant = 1'b1;
    set_issue(1, 4'd10, 32'd9, 32'd9, 5'd22);
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("flush_clear", {cdb_valid, busy}, 2'b00);
    for (int i = 0; i < 6; i++) step();
    drain();

    set_issue(1, 4'd10, 32'd2, 32'd3, 5'd25);
    step();
    set_issue(1, 4'd10, 32'd4, 32'd5, 5'd26);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    issue_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    drain();
    grant_hi = 1'b1;

    set_issue(1, 4'd11, 32'h8000_0000, 32'd2, 5'd9);
    step();
    issue_valid = 1'b0;
`ifdef OTTER_ALU_MULH_EN
    step();
    step();
    chk("mulh", {cdb_valid, cdb_val}, {1'b1, 32'hFFFF_FFFF});
`else
    chk("code11_zero", {cdb_valid, cdb_tag, cdb_val}, {1'b1, 5'd9, 32'd0});
`endif
    drain();

    for (int i = 0; i < 300; i++) begin
      set_issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 5'($urandom));
      step();
    end
    drain();

    grant_hi = 1'b0;
    for (int i = 0; i < 600; i++) begin
      set_issue(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), rnd_val(), rnd_val(), 5'($urandom));
      cdb_grant = $urandom_range(0, 9) < 7;
      flush = $urandom_range(0, 99) < 3;
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
